// File: rtl/uart_pkg.sv
// Shared UART definitions: receive-sampler state encoding, frame width and
// the baud divider calculation used by both receive and transmit paths.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        FLUSH
    } rx_samp_state_t;

    localparam int UART_DATA_BITS = 8;

    // Clock cycles per oversample tick; never below one so the tick still runs.
    function automatic int calc_div(input int clk_freq, input int baud, input int os);
        int d;
        d = clk_freq / (baud * os);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: pulses tick once every DIV cycles. While clear
// is high the count is treated as zero, so the clear cycle is count 0.
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt;

    assign w_cnt = clear ? '0 : r_cnt;
    assign tick  = (w_cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_sampler.sv
// UART receive front end: synchronises rx_pin, validates the start bit and
// strobes 11 cleaned bits per frame. Build option: UART_RX_MAJORITY_EN.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_pin,
    output logic rx_bit,
    output logic sample_enable,
    output logic busy,
    output logic frame_error
);
    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int OSW = $clog2(OVERSAMPLE);
    localparam logic [OSW-1:0] OS_HALF  = OSW'(OVERSAMPLE / 2 - 1);
    localparam logic [OSW-1:0] OS_LAST  = OSW'(OVERSAMPLE - 1);
    localparam logic [2:0]     LAST_BIT = 3'(UART_DATA_BITS - 1);

    logic           r_sync1;
    logic           r_sync2;
    logic           r_prev;
    rx_samp_state_t r_state;
    logic [OSW-1:0] r_os_cnt;
    logic [2:0]     r_bit_idx;
    logic           r_rx_bit;
    logic           r_sample_en;
    logic           r_busy;
    logic           r_frame_err;
    logic           w_detect;
    logic           w_tick;
    logic           w_v;

    assign rx_bit        = r_rx_bit;
    assign sample_enable = r_sample_en;
    assign busy          = r_busy;
    assign frame_error   = r_frame_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= rx_pin;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_detect = (r_state == IDLE) && r_prev && !r_sync2;

    uart_baud_tick #(
        .DIV(DIV)
    ) u_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .clear(w_detect),
        .tick (w_tick)
    );

`ifdef UART_RX_MAJORITY_EN
    // Window of the last three tick samples, the newest being the live value.
    logic [1:0] r_hist;
    logic [2:0] w_hist;

    assign w_hist = {r_hist, r_sync2};
    assign w_v    = (w_hist[0] & w_hist[1]) | (w_hist[0] & w_hist[2]) | (w_hist[1] & w_hist[2]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist <= 2'b11;
        end else if (w_tick) begin
            r_hist <= w_hist[1:0];
        end
    end
`else
    assign w_v = r_sync2;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_os_cnt    <= '0;
            r_bit_idx   <= '0;
            r_rx_bit    <= 1'b1;
            r_sample_en <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_sample_en <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_detect) begin
                        r_os_cnt  <= '0;
                        r_bit_idx <= '0;
                        r_state   <= START;
                        r_busy    <= 1'b1;
                    end
                end
                START: begin
                    if (w_tick) begin
                        if (r_os_cnt == OS_HALF) begin
                            r_os_cnt <= '0;
                            if (!w_v) begin
                                r_sample_en <= 1'b1;
                                r_rx_bit    <= 1'b0;
                                r_state     <= DATA;
                            end else begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_os_cnt <= r_os_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        if (r_os_cnt == OS_LAST) begin
                            r_os_cnt    <= '0;
                            r_sample_en <= 1'b1;
                            r_rx_bit    <= w_v;
                            r_bit_idx   <= r_bit_idx + 1'b1;
                            if (r_bit_idx == LAST_BIT) begin
                                r_state <= STOP;
                            end
                        end else begin
                            r_os_cnt <= r_os_cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        if (r_os_cnt == OS_LAST) begin
                            r_os_cnt    <= '0;
                            r_sample_en <= 1'b1;
                            r_rx_bit    <= w_v;
                            r_frame_err <= !w_v;
                            r_state     <= FLUSH;
                        end else begin
                            r_os_cnt <= r_os_cnt + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    // Extra strobe of 1 wraps the downstream bit counter back to 0.
                    r_sample_en <= 1'b1;
                    r_rx_bit    <= 1'b1;
                    r_state     <= IDLE;
                    r_busy      <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Bench for uart_rx_sampler: serial frames in, strobe stream compared with a
// frame-level model of the expected bits, flags and strobe timing.
`timescale 1ns/1ps
module tb_uart_rx_sampler;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 10_000;
  localparam int OS       = 16;
  localparam int DIV      = CLK_FREQ / (BAUD * OS);
  localparam int BIT      = DIV * OS;
  // busy rises one cycle after detect, start strobe comes BIT/2 after detect
  localparam int FIRST    = BIT / 2 - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_pin = 1'b1;
  logic rx_bit, sample_enable, busy, frame_error;

  uart_rx_sampler #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD(BAUD),
    .OVERSAMPLE(OS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_pin(rx_pin),
    .rx_bit(rx_bit),
    .sample_enable(sample_enable),
    .busy(busy),
    .frame_error(frame_error)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // observation queues
  int   se_cyc_q[$];
  logic se_bit_q[$];
  logic se_fe_q[$];
  int   rise_q[$];
  int   fall_q[$];
  int   fe_total = 0;
  logic busy_d = 1'b0;
  int   drop_cyc = 0;

  always @(negedge clk) begin
    if (sample_enable === 1'b1) begin
      se_cyc_q.push_back(cyc);
      se_bit_q.push_back(rx_bit);
      se_fe_q.push_back(frame_error);
    end
    if (frame_error === 1'b1) fe_total++;
    if (busy === 1'b1 && busy_d === 1'b0) rise_q.push_back(cyc);
    if (busy === 1'b0 && busy_d === 1'b1) fall_q.push_back(cyc);
    busy_d = busy;
  end

  // expected queues and counters
  logic exp_q[$];
  logic exp_fe_q[$];
  int   exp_off_q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic clear_obs();
    se_cyc_q.delete(); se_bit_q.delete(); se_fe_q.delete();
    rise_q.delete(); fall_q.delete(); fe_total = 0;
    exp_q.delete(); exp_fe_q.delete(); exp_off_q.delete();
  endtask

  // Frame model: start 0, data LSB first, stop, then a flush 1 one cycle later.
  task automatic model_frame(input logic [7:0] d, input logic stop);
    for (int i = 0; i < 11; i++) begin
      if (i == 0) exp_q.push_back(1'b0);
      else if (i <= 8) exp_q.push_back(d[i-1]);
      else if (i == 9) exp_q.push_back(stop);
      else exp_q.push_back(1'b1);
      exp_fe_q.push_back((i == 9) && !stop);
      if (i <= 9) exp_off_q.push_back(FIRST + BIT * i);
      else exp_off_q.push_back(FIRST + BIT * 9 + 1);
    end
  endtask

  // driver tasks
  task automatic send_frame(input logic [7:0] d, input logic stop, input int glitch_at, input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      int   idx;
      logic lvl;
      idx = k / BIT;
      if (idx == 0) lvl = 1'b0;
      else if (idx <= 8) lvl = d[idx-1];
      else lvl = stop;
      if (k == glitch_at) lvl = ~lvl;
      @(negedge clk);
      if (k == 0) drop_cyc = cyc;
      rx_pin = lvl;
    end
  endtask

  task automatic line_hold(input logic lvl, input int n);
    repeat (n) begin
      @(negedge clk);
      rx_pin = lvl;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_pin = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (sample_enable !== 1'b0) $display("FAIL reset_se: got %b want 0", sample_enable); else n_pass++;
    n_checks++; if (frame_error !== 1'b0) $display("FAIL reset_fe: got %b want 0", frame_error); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (rx_bit !== 1'b1) $display("FAIL reset_rx_bit: got %b want 1", rx_bit); else n_pass++;
    rst = 1'b0;
    clear_obs();
    line_hold(1'b1, 20);
    n_checks++; if (se_bit_q.size() != 0 || busy !== 1'b0) $display("FAIL idle_after_reset: strobes %0d busy %b want 0 0", se_bit_q.size(), busy); else n_pass++;
  endtask

  task automatic test_frame_a5();
    logic [7:0] rx_data;
    clear_obs();
    model_frame(8'hA5, 1'b1);
    send_frame(8'hA5, 1'b1, -1, 10 * BIT);
    line_hold(1'b1, 20);
    n_checks++; if (se_bit_q.size() != 11) $display("FAIL a5_count: got %0d want 11", se_bit_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < se_bit_q.size(); i++) begin
      int off;
      off = (i / 11 < rise_q.size()) ? se_cyc_q[i] - rise_q[i/11] : -1;
      n_checks++;
      if (se_bit_q[i] !== exp_q[i] || se_fe_q[i] !== exp_fe_q[i] || off != exp_off_q[i])
        $display("FAIL a5_strobe %0d: bit %b fe %b off %0d, want bit %b fe %b off %0d", i, se_bit_q[i], se_fe_q[i], off, exp_q[i], exp_fe_q[i], exp_off_q[i]);
      else n_pass++;
    end
    rx_data = '0;
    for (int i = 1; i <= 8 && i < se_bit_q.size(); i++) rx_data[i-1] = se_bit_q[i];
    n_checks++; if (rx_data !== 8'hA5) $display("FAIL a5_rx_data: got %h want a5", rx_data); else n_pass++;
    n_checks++; if (fe_total != 0) $display("FAIL a5_frame_error: got %0d pulses want 0", fe_total); else n_pass++;
    n_checks++;
    if (rise_q.size() != 1 || rise_q[0] - drop_cyc < 3 || rise_q[0] - drop_cyc > 4)
      $display("FAIL a5_detect_latency: rises %0d delay %0d want 1 rise, delay 3..4", rise_q.size(), (rise_q.size() > 0) ? rise_q[0] - drop_cyc : -1);
    else n_pass++;
    n_checks++; if (busy !== 1'b0 || rx_bit !== 1'b1) $display("FAIL a5_idle_after: busy %b rx_bit %b want 0 1", busy, rx_bit); else n_pass++;
  endtask

  task automatic test_glitch();
    clear_obs();
    send_frame(8'h00, 1'b1, -1, 40);
    for (int k = 0; k < 300 && fall_q.size() == 0; k++) line_hold(1'b1, 1);
    line_hold(1'b1, 10);
    n_checks++; if (se_bit_q.size() != 0) $display("FAIL glitch_strobes: got %0d want 0", se_bit_q.size()); else n_pass++;
    n_checks++;
    if (rise_q.size() != 1 || fall_q.size() != 1 || fall_q[0] - rise_q[0] != FIRST)
      $display("FAIL glitch_busy: rises %0d falls %0d width %0d want 1 1 %0d", rise_q.size(), fall_q.size(), (rise_q.size() == 1 && fall_q.size() == 1) ? fall_q[0] - rise_q[0] : -1, FIRST);
    else n_pass++;
  endtask

  task automatic test_frame_error_break();
    clear_obs();
    model_frame(8'h3C, 1'b0);
    model_frame(8'h01, 1'b1);
    send_frame(8'h3C, 1'b0, -1, 10 * BIT);
    line_hold(1'b0, 3000);
    line_hold(1'b1, 200);
    send_frame(8'h01, 1'b1, -1, 10 * BIT);
    line_hold(1'b1, 20);
    n_checks++; if (se_bit_q.size() != 22) $display("FAIL ferr_count: got %0d want 22", se_bit_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < se_bit_q.size(); i++) begin
      int off;
      off = (i / 11 < rise_q.size()) ? se_cyc_q[i] - rise_q[i/11] : -1;
      n_checks++;
      if (se_bit_q[i] !== exp_q[i] || se_fe_q[i] !== exp_fe_q[i] || off != exp_off_q[i])
        $display("FAIL ferr_strobe %0d: bit %b fe %b off %0d, want bit %b fe %b off %0d", i, se_bit_q[i], se_fe_q[i], off, exp_q[i], exp_fe_q[i], exp_off_q[i]);
      else n_pass++;
    end
    n_checks++; if (fe_total != 1) $display("FAIL ferr_pulses: got %0d want 1", fe_total); else n_pass++;
    n_checks++; if (rise_q.size() != 2) $display("FAIL break_frames: got %0d frames want 2", rise_q.size()); else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    d = 8'($urandom_range(0, 255));
    clear_obs();
    send_frame(d, 1'b1, -1, 5 * BIT + 80);
    n_checks++; if (se_bit_q.size() != 5) $display("FAIL midrst_pre_strobes: got %0d want 5", se_bit_q.size()); else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    rx_pin = 1'b1;
    @(negedge clk);
    n_checks++;
    if (sample_enable !== 1'b0 || frame_error !== 1'b0 || busy !== 1'b0 || rx_bit !== 1'b1)
      $display("FAIL midrst_outputs: se %b fe %b busy %b rx_bit %b want 0 0 0 1", sample_enable, frame_error, busy, rx_bit);
    else n_pass++;
    rst = 1'b0;
    clear_obs();
    line_hold(1'b1, 400);
    n_checks++; if (se_bit_q.size() != 0 || busy !== 1'b0) $display("FAIL midrst_quiet: strobes %0d busy %b want 0 0", se_bit_q.size(), busy); else n_pass++;
    clear_obs();
    model_frame(8'hFF, 1'b1);
    send_frame(8'hFF, 1'b1, -1, 10 * BIT);
    line_hold(1'b1, 20);
    n_checks++; if (se_bit_q.size() != 11) $display("FAIL midrst_ff_count: got %0d want 11", se_bit_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < se_bit_q.size(); i++) begin
      int off;
      off = (i / 11 < rise_q.size()) ? se_cyc_q[i] - rise_q[i/11] : -1;
      n_checks++;
      if (se_bit_q[i] !== exp_q[i] || se_fe_q[i] !== exp_fe_q[i] || off != exp_off_q[i])
        $display("FAIL midrst_ff_strobe %0d: bit %b fe %b off %0d, want bit %b fe %b off %0d", i, se_bit_q[i], se_fe_q[i], off, exp_q[i], exp_fe_q[i], exp_off_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int n_ferr;
    n_ferr = 0;
    clear_obs();
    for (int f = 0; f < 5; f++) begin
      logic [7:0] d;
      logic       stop;
      d = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      if (!stop) n_ferr++;
      model_frame(d, stop);
      send_frame(d, stop, -1, 10 * BIT);
      if (!stop) line_hold(1'b1, $urandom_range(2, 20));
      else line_hold(1'b1, $urandom_range(0, 20));
    end
    line_hold(1'b1, 20);
    n_checks++; if (se_bit_q.size() != 55) $display("FAIL b2b_count: got %0d want 55", se_bit_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < se_bit_q.size(); i++) begin
      int off;
      off = (i / 11 < rise_q.size()) ? se_cyc_q[i] - rise_q[i/11] : -1;
      n_checks++;
      if (se_bit_q[i] !== exp_q[i] || se_fe_q[i] !== exp_fe_q[i] || off != exp_off_q[i])
        $display("FAIL b2b_strobe %0d: bit %b fe %b off %0d, want bit %b fe %b off %0d", i, se_bit_q[i], se_fe_q[i], off, exp_q[i], exp_fe_q[i], exp_off_q[i]);
      else n_pass++;
    end
    n_checks++; if (fe_total != n_ferr) $display("FAIL b2b_frame_errors: got %0d want %0d", fe_total, n_ferr); else n_pass++;
  endtask

`ifdef UART_RX_MAJORITY_EN
  task automatic test_majority();
    for (int delta = -1; delta <= 1; delta++) begin
      int         j;
      logic [7:0] d;
      j = $urandom_range(0, 7);
      d = 8'($urandom_range(0, 255));
      d[j] = 1'b0;
      clear_obs();
      model_frame(d, 1'b1);
      // pin offset seen by the decision tick of data bit j
      send_frame(d, 1'b1, BIT / 2 - 1 + BIT * (j + 1) + delta, 10 * BIT);
      line_hold(1'b1, 20);
      n_checks++; if (se_bit_q.size() != 11) $display("FAIL maj_count: got %0d want 11", se_bit_q.size()); else n_pass++;
      for (int i = 0; i < exp_q.size() && i < se_bit_q.size(); i++) begin
        int off;
        off = (i / 11 < rise_q.size()) ? se_cyc_q[i] - rise_q[i/11] : -1;
        n_checks++;
        if (se_bit_q[i] !== exp_q[i] || se_fe_q[i] !== exp_fe_q[i] || off != exp_off_q[i])
          $display("FAIL maj_strobe %0d (bit %0d delta %0d): bit %b fe %b off %0d, want bit %b fe %b off %0d", i, j, delta, se_bit_q[i], se_fe_q[i], off, exp_q[i], exp_fe_q[i], exp_off_q[i]);
        else n_pass++;
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_frame_a5();
    test_glitch();
    test_frame_error_break();
    test_reset_mid_frame();
    test_back_to_back();
`ifdef UART_RX_MAJORITY_EN
    test_majority();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_sampler.md
# uart_rx_sampler

Front end of the UART receive path: it synchronises the asynchronous serial pin, detects and validates the start bit, and times bit centres with an oversampling baud tick. It drives the receive shift register directly with a cleaned bit (`rx_bit`) and single-cycle `sample_enable` strobes, 11 per frame. It also flags framing errors.

## Interface
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `BAUD`, 115200: line rate in bit/s.
- `OVERSAMPLE`, 16: ticks per bit; must be even and ≥ 4.
- `clk` input 1: system clock. One clock domain.
- `rst` input 1: reset, synchronous, active-high.
- `rx_pin` input 1: asynchronous serial line; idles high.
- `rx_bit` output 1: sampled bit value; valid whenever `sample_enable` = 1.
- `sample_enable` output 1: one-cycle strobe to the shift register.
- `busy` output 1: high in every state except IDLE.
- `frame_error` output 1: one-cycle pulse when the stop bit is sampled as 0.

## Operation
- Local constant `DIV = CLK_FREQ / (BAUD*OVERSAMPLE)`, truncated integer division, minimum 1.
- Tick counter: width `$clog2(DIV)` bits, counts 0..DIV-1 and asserts `tick` when it wraps. It is forced to 0 on the cycle a start edge is detected.
- Synchroniser: two flops on `rx_pin` produce `rx_sync`. A third flop holds `rx_prev` for edge detection.
- Sampled value `v`: `rx_sync` at the decision tick. With majority voting compiled in, see Configuration.
- States and transitions:
  - IDLE: when `rx_prev` = 1 and `rx_sync` = 0, clear the tick and bit counters and go to START.
  - START: at tick OVERSAMPLE/2:
    - if `v` = 0: pulse `sample_enable` with `rx_bit` = 0, go to DATA.
    - else (false start): go to IDLE with no pulse.
  - DATA: every OVERSAMPLE ticks, pulse with `rx_bit` = `v`. After the 8th data bit (3-bit index wraps 7→0), go to STOP.
  - STOP: after OVERSAMPLE ticks, pulse with `rx_bit` = `v`. If `v` = 0, also pulse `frame_error` in the same cycle. Go to FLUSH.
  - FLUSH: pulse `sample_enable` with `rx_bit` = 1 for exactly one cycle, go to IDLE. This 11th strobe returns the shift register's bit counter to 0, so its `data_ready` is high for exactly one clock.
- Break condition (line held low): after FLUSH, IDLE waits for a fresh 1→0 edge. No spurious frame is started.
- Falling edges while busy are ignored; there is no resynchronisation mid-frame.
- `rx_bit` holds its last value when `sample_enable` = 0.

## Timing
- Reset values: `sample_enable` = 0, `frame_error` = 0, `busy` = 0, `rx_bit` = 1, state = IDLE. Synchroniser flops, `rx_prev` and majority history all reset to 1.
- `rst` asserted mid-frame returns to IDLE on the next edge with no further strobes.
- Edge detection occurs 2–3 cycles after `rx_pin` falls (synchroniser latency).
- Start strobe: `DIV*OVERSAMPLE/2` cycles after the detect cycle.
- Data and stop strobes: every `DIV*OVERSAMPLE` cycles after the start strobe.
- FLUSH strobe: exactly 1 cycle after the stop strobe.
- `busy` rises the cycle after detection and falls the cycle after FLUSH.

## Configuration
- Macro: `UART_RX_MAJORITY_EN`.
- Defined: a 3-bit history shifts in `rx_sync` on every tick, and `v` = majority of the 3 samples. This applies to start validation and to every bit sample.
- Undefined: `v` = `rx_sync` at the decision tick, with no history register.
- Strobe timing is identical in both builds.

## Structure
- Package `uart_pkg`:
  - state enum `rx_samp_state_t` {IDLE, START, DATA, STOP, FLUSH};
  - `UART_DATA_BITS` = 8;
  - function `calc_div(clk_freq, baud, os)`.
- Sub-module `uart_baud_tick`: parameter DIV, inputs `clk`, `rst`, `clear`, output `tick`. The same block is reused by the transmit path.

## Test plan
Bench parameters: CLK_FREQ=1_600_000, BAUD=10_000, OVERSAMPLE=16, giving DIV=10 and 160 cycles per bit.
- Send frame 0xA5, LSB first, stop bit 1:
  - exactly 11 strobes; `rx_bit` sequence 0,1,0,1,0,0,1,0,1,1,1;
  - first strobe 80 cycles after detect; `frame_error` stays 0;
  - with the shift register attached, `rx_data` = 0xA5 and `data_ready` high for one cycle.
- Low glitch on `rx_pin` for 40 cycles: no strobe, `busy` returns to 0 at tick 8.
- Frame 0x3C with stop bit 0: `frame_error` pulses with the 10th strobe; the 11th strobe follows 1 cycle later.
- Line held low for 3000 cycles after that frame: only one frame; the next frame (0x01) after the line returns high decodes correctly.
- `rst` held one cycle at data bit 4: no strobes afterwards, all outputs at reset values; a following frame 0xFF decodes correctly.
- With the macro defined, a single-cycle high pulse at data-bit centre while the bit is 0: `rx_bit` = 0 for that bit.
